game_text_overlay: RTL and testbench

Parametrised pixel-stream text overlay for the VGA path. It holds a glyph bitmap store and a fixed message table, and maps the current (DrawX, DrawY) scan position to a registered `text_on` bit after a fixed 2-cycle latency. It adds four features that a plain font ROM does not have:
- integer power-of-two scaling;
- a programmable screen origin;
- frame-synchronous blink and typewriter-reveal modes.

It sits between the VGA controller's coordinate outputs and the colour mapper, which delays its own background path by 2 cycles to stay aligned.

---
 rtl/game_text_overlay.sv | 249 ++++++++++++++++++++++++
 tb/tb_game_text_overlay.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_text_overlay.sv
// game_text_overlay: two-stage pixel pipeline that maps the scan position
// to a lit/unlit text bit, with power-of-two scaling, a per-frame origin and
// frame-synchronous OFF / STEADY / BLINK / REVEAL display modes.
// Glyph and message contents are compile-time constant tables.
module game_text_overlay #(
  parameter int GLYPH_W       = 8,
  parameter int GLYPH_H       = 16,
  parameter int NUM_GLYPHS    = 8,
  parameter int MSG_LEN       = 9,
  parameter int SCALE_LOG2    = 1,
  parameter int BLINK_FRAMES  = 30,
  parameter int REVEAL_FRAMES = 8,
  localparam int GI_W = $clog2(NUM_GLYPHS),
  localparam int SL_W = $clog2(MSG_LEN)
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            frame_start,
  input  logic [9:0]      DrawX,
  input  logic [9:0]      DrawY,
  input  logic [9:0]      OrigX,
  input  logic [9:0]      OrigY,
  input  logic [1:0]      mode,
  output logic            text_on,
  output logic [SL_W-1:0] char_slot,
  output logic            reveal_done
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_STEADY = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_REVEAL = 2'b11
  } mode_t;

  localparam int GW_LOG2 = $clog2(GLYPH_W);
  localparam int GH_LOG2 = $clog2(GLYPH_H);
  localparam int WIN_W   = (MSG_LEN * GLYPH_W) << SCALE_LOG2;
  localparam int WIN_H   = GLYPH_H << SCALE_LOG2;
  localparam int RC_W    = $clog2(MSG_LEN + 1);
  localparam int FC_MAX  = (BLINK_FRAMES > REVEAL_FRAMES) ? BLINK_FRAMES : REVEAL_FRAMES;
  localparam int FC_W    = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;

  localparam logic [10:0]     WIN_W_L     = 11'(WIN_W);
  localparam logic [10:0]     WIN_H_L     = 11'(WIN_H);
  localparam logic [RC_W-1:0] RC_FULL     = RC_W'(MSG_LEN);
  localparam logic [FC_W-1:0] BLINK_LAST  = FC_W'(BLINK_FRAMES - 1);
  localparam logic [FC_W-1:0] REVEAL_LAST = FC_W'(REVEAL_FRAMES - 1);

  // Glyph rows 2..11 of each letter, first row in the top byte.
  function automatic logic [79:0] font_bits(input logic [GI_W-1:0] g);
    case (32'(g))
      0:       font_bits = 80'h3C66C0C0C0CEC6C6663E; // G
      1:       font_bits = 80'h183C66C3C3FFC3C3C3C3; // A
      2:       font_bits = 80'hC3E7FFDBC3C3C3C3C3C3; // M
      3:       font_bits = 80'hFFC0C0C0FCC0C0C0C0FF; // E
      4:       font_bits = 80'h3C66C3C3C3C3C3C3663C; // O
      5:       font_bits = 80'hC3C3C3C3C3C366663C18; // V
      6:       font_bits = 80'hFCC6C6C6FCD8CCC6C3C3; // R
      default: font_bits = '0;                       // blank
    endcase
  endfunction

  // One glyph-store word; bit GLYPH_W-1 is the leftmost pixel.
  function automatic logic [GLYPH_W-1:0] glyph_word(input logic [GI_W-1:0] g,
                                                    input logic [GH_LOG2-1:0] row);
    logic [79:0]        bits;
    logic [7:0]         b8;
    logic [GLYPH_W-1:0] w;
    int unsigned        r;
    bits = font_bits(g);
    r    = 32'(row);
    b8   = '0;
    if (r >= 2 && r <= 11) b8 = bits[79 - 8*(r-2) -: 8];
    w = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < GLYPH_W) w[GLYPH_W-1-i] = b8[7-i];
    end
    return w;
  endfunction

  // Message table: "GAME OVER"; unused slots map to the blank glyph.
  function automatic logic [GI_W-1:0] msg_entry(input logic [SL_W-1:0] s);
    case (32'(s))
      0:       msg_entry = GI_W'(0);
      1:       msg_entry = GI_W'(1);
      2:       msg_entry = GI_W'(2);
      3:       msg_entry = GI_W'(3);
      4:       msg_entry = GI_W'(7);
      5:       msg_entry = GI_W'(4);
      6:       msg_entry = GI_W'(5);
      7:       msg_entry = GI_W'(3);
      8:       msg_entry = GI_W'(6);
      default: msg_entry = GI_W'(NUM_GLYPHS - 1);
    endcase
  endfunction

  // Frame-latched state
  mode_t             r_mode,       w_mode_nx;
  logic [9:0]        r_orig_x,     w_orig_x_nx;
  logic [9:0]        r_orig_y,     w_orig_y_nx;
  logic [FC_W-1:0]   r_frame_cnt,  w_frame_cnt_nx;
  logic [RC_W-1:0]   r_reveal_cnt, w_reveal_cnt_nx;
  logic              r_visible,    w_visible_nx;

  // Stage 1
  logic [10:0]        w_rx, w_ry;
  logic               w_inside, w_en;
  logic [SL_W-1:0]    w_slot;
  logic [GW_LOG2-1:0] w_col;
  logic [GH_LOG2-1:0] w_row;
  logic               r_inside, r_en;
  logic [SL_W-1:0]    r_slot;
  logic [GW_LOG2-1:0] r_col;
  logic [GH_LOG2-1:0] r_row;

  // Stage 2
  logic [GLYPH_W-1:0] r_rowdata;
  logic               r_inside_d, r_en_d;
  logic [SL_W-1:0]    r_slot_d;
  logic [GW_LOG2-1:0] r_col_d;
  logic [GW_LOG2-1:0] w_bit_idx;

  // Frame control state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_mode       <= MODE_OFF;
      r_orig_x     <= '0;
      r_orig_y     <= '0;
      r_frame_cnt  <= '0;
      r_reveal_cnt <= '0;
      r_visible    <= 1'b1;
    end else begin
      r_mode       <= w_mode_nx;
      r_orig_x     <= w_orig_x_nx;
      r_orig_y     <= w_orig_y_nx;
      r_frame_cnt  <= w_frame_cnt_nx;
      r_reveal_cnt <= w_reveal_cnt_nx;
      r_visible    <= w_visible_nx;
    end
  end

  // Frame control next state: everything changes only on frame_start
  always_comb begin
    w_mode_nx       = r_mode;
    w_orig_x_nx     = r_orig_x;
    w_orig_y_nx     = r_orig_y;
    w_frame_cnt_nx  = r_frame_cnt;
    w_reveal_cnt_nx = r_reveal_cnt;
    w_visible_nx    = r_visible;
    if (frame_start) begin
      w_mode_nx   = mode_t'(mode);
      w_orig_x_nx = OrigX;
      w_orig_y_nx = OrigY;
      case (mode_t'(mode))
        MODE_OFF: begin
          w_frame_cnt_nx  = '0;
          w_reveal_cnt_nx = '0;
          w_visible_nx    = 1'b1;
        end
        MODE_STEADY: begin
          w_frame_cnt_nx  = '0;
          w_reveal_cnt_nx = RC_FULL;
          w_visible_nx    = 1'b1;
        end
        MODE_BLINK: begin
          w_reveal_cnt_nx = RC_FULL;
          if (r_mode != MODE_BLINK) begin
            w_frame_cnt_nx = '0;
            w_visible_nx   = 1'b1;
          end else if (r_frame_cnt == BLINK_LAST) begin
            w_frame_cnt_nx = '0;
            w_visible_nx   = ~r_visible;
          end else begin
            w_frame_cnt_nx = r_frame_cnt + FC_W'(1);
          end
        end
        MODE_REVEAL: begin
          w_visible_nx = 1'b1;
          if (r_mode != MODE_REVEAL) begin
            w_frame_cnt_nx  = '0;
            w_reveal_cnt_nx = '0;
          end else if (r_frame_cnt == REVEAL_LAST) begin
            w_frame_cnt_nx = '0;
            if (r_reveal_cnt != RC_FULL) w_reveal_cnt_nx = r_reveal_cnt + RC_W'(1);
          end else begin
            w_frame_cnt_nx = r_frame_cnt + FC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign reveal_done = (r_mode == MODE_REVEAL) && (r_reveal_cnt == RC_FULL);

  // Stage 1 position decode: sign bit rejects left/top overhang, the window
  // compare rejects right/bottom overhang, so no wrap-around is possible.
  always_comb begin
    w_rx     = {1'b0, DrawX} - {1'b0, r_orig_x};
    w_ry     = {1'b0, DrawY} - {1'b0, r_orig_y};
    w_inside = !w_rx[10] && (w_rx < WIN_W_L) && !w_ry[10] && (w_ry < WIN_H_L);
    w_slot   = w_rx[SCALE_LOG2 + GW_LOG2 +: SL_W];
    w_col    = w_rx[SCALE_LOG2 +: GW_LOG2];
    w_row    = w_ry[SCALE_LOG2 +: GH_LOG2];
    // Display enable is taken with the pixel so a frame_start while the
    // pixel is in flight cannot change its outcome.
    w_en     = (r_mode != MODE_OFF) && r_visible && (RC_W'(w_slot) < r_reveal_cnt);
  end

  // Stage 1 pipeline registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_inside <= 1'b0;
      r_en     <= 1'b0;
      r_slot   <= '0;
      r_col    <= '0;
      r_row    <= '0;
    end else begin
      r_inside <= w_inside;
      r_en     <= w_en;
      r_slot   <= w_slot;
      r_col    <= w_col;
      r_row    <= w_row;
    end
  end

  // Stage 2: synchronous glyph-store read plus delayed pixel attributes
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rowdata  <= '0;
      r_inside_d <= 1'b0;
      r_en_d     <= 1'b0;
      r_slot_d   <= '0;
      r_col_d    <= '0;
    end else begin
      r_rowdata  <= glyph_word(msg_entry(r_slot), r_row);
      r_inside_d <= r_inside;
      r_en_d     <= r_en;
      r_slot_d   <= r_slot;
      r_col_d    <= r_col;
    end
  end

  assign w_bit_idx = GW_LOG2'(GLYPH_W - 1) - r_col_d;
  assign text_on   = r_inside_d && r_en_d && r_rowdata[w_bit_idx];
  assign char_slot = r_inside_d ? r_slot_d : '0;

endmodule

// File: tb/tb_game_text_overlay.sv
// Scoreboard bench for game_text_overlay: a driver pushes expected pixel
// results from a letter-art reference model; a monitor pops and compares
// them when they leave the two-stage pipeline.
module tb_game_text_overlay;

  localparam int MSG_LEN = 9;
  localparam int GW      = 8;
  localparam int GH      = 16;
  localparam int SCL     = 2;
  localparam int BF      = 2;
  localparam int RF      = 1;
  localparam int WIN_W   = MSG_LEN * GW * SCL;
  localparam int WIN_H   = GH * SCL;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, OrigX = '0, OrigY = '0;
  logic [1:0] mode = '0;
  logic       text_on;
  logic [3:0] char_slot;
  logic       reveal_done;

  game_text_overlay #(
    .GLYPH_W(8), .GLYPH_H(16), .NUM_GLYPHS(8), .MSG_LEN(9), .SCALE_LOG2(1),
    .BLINK_FRAMES(BF), .REVEAL_FRAMES(RF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .OrigX(OrigX), .OrigY(OrigY), .mode(mode),
    .text_on(text_on), .char_slot(char_slot), .reveal_done(reveal_done)
  );

  always #5 Clk = ~Clk;

  typedef struct { int x; int y; bit t; int s; } item_t;
  item_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit drv_valid = 0, v1 = 0, v2 = 0;

  // Reference model state: mode in force, origin, frames since mode entry.
  int m_mode = 0, m_ox = 0, m_oy = 0, m_k = 0;
  bit m_rst = 1;
  string font[7];
  int msg[MSG_LEN] = '{0, 1, 2, 3, 7, 4, 5, 3, 6};

  function automatic bit lit(int g, int row, int col);
    if (g > 6 || row < 2 || row > 11) return 0;
    return font[g][(row - 2) * 8 + col] == "#";
  endfunction

  function automatic bit shown(int slot);
    int rev;
    case (m_mode)
      0: return 0;
      1: return 1;
      2: return ((m_k / BF) % 2) == 0;
      default: begin
        rev = m_k / RF;
        if (rev > MSG_LEN) rev = MSG_LEN;
        return slot < rev;
      end
    endcase
  endfunction

  function automatic bit exp_done();
    return (m_mode == 3) && (m_k / RF >= MSG_LEN);
  endfunction

  function automatic void expect_pix(int x, int y, output bit t, output int s);
    int rx, ry, slot;
    t = 0; s = 0;
    if (m_rst) return;
    rx = x - m_ox;
    ry = y - m_oy;
    if (rx < 0 || rx >= WIN_W || ry < 0 || ry >= WIN_H) return;
    slot = rx / (GW * SCL);
    s = slot;
    t = lit(msg[slot], ry / SCL, (rx / SCL) % GW) && shown(slot);
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Driver: one pixel per cycle, expected result pushed to the scoreboard.
  task automatic drive(input int xi, input int yi, input bit fs, input bit chk);
    item_t it;
    int x, y;
    x = xi & 1023;
    y = yi & 1023;
    @(negedge Clk);
    if (!m_rst) check("reveal_done", int'(reveal_done), int'(exp_done()));
    DrawX = 10'(x);
    DrawY = 10'(y);
    frame_start = fs;
    it.x = x;
    it.y = y;
    expect_pix(x, y, it.t, it.s);
    if (chk) q.push_back(it);
    drv_valid = chk;
    if (fs && !m_rst) begin
      if (int'(mode) == m_mode) m_k++;
      else m_k = 0;
      m_mode = int'(mode);
      m_ox = int'(OrigX);
      m_oy = int'(OrigY);
    end
  endtask

  task automatic idle(int n);
    repeat (n) drive(int'(DrawX), int'(DrawY), 0, 0);
  endtask

  task automatic frame(int md, int ox, int oy);
    mode  = 2'(md);
    OrigX = 10'(ox);
    OrigY = 10'(oy);
    drive(0, 0, 1, 1);
  endtask

  task automatic rand_pix(int n);
    repeat (n)
      drive(m_ox - 8 + int'($urandom_range(0, WIN_W + 16)),
            m_oy - 4 + int'($urandom_range(0, WIN_H + 8)), 0, 1);
  endtask

  task automatic steady_points();
    drive(104, 204, 0, 1);
    drive(100, 204, 0, 1);
    drive(99, 204, 0, 1);
    drive(244, 204, 0, 1);
    drive(180, 214, 0, 1);
  endtask

  // Valid pipeline matching the DUT latency.
  always @(posedge Clk) begin
    v1 <= drv_valid;
    v2 <= v1;
  end

  // Monitor: compare whatever leaves the pipeline against the scoreboard.
  always @(posedge Clk) begin
    item_t it;
    #1;
    if (v2) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        it = q.pop_front();
        check($sformatf("text_on(%0d,%0d)", it.x, it.y), int'(text_on), int'(it.t));
        check($sformatf("char_slot(%0d,%0d)", it.x, it.y), int'(char_slot), it.s);
      end
    end
  end

  initial begin
    bit t;
    int s;
    font[0] = {"..####..", ".##..##.", "##......", "##......", "##......",
               "##..###.", "##...##.", "##...##.", ".##..##.", "..#####."};
    font[1] = {"...##...", "..####..", ".##..##.", "##....##", "##....##",
               "########", "##....##", "##....##", "##....##", "##....##"};
    font[2] = {"##....##", "###..###", "########", "##.##.##", "##....##",
               "##....##", "##....##", "##....##", "##....##", "##....##"};
    font[3] = {"########", "##......", "##......", "##......", "######..",
               "##......", "##......", "##......", "##......", "########"};
    font[4] = {"..####..", ".##..##.", "##....##", "##....##", "##....##",
               "##....##", "##....##", "##....##", ".##..##.", "..####.."};
    font[5] = {"##....##", "##....##", "##....##", "##....##", "##....##",
               "##....##", ".##..##.", ".##..##.", "..####..", "...##..."};
    font[6] = {"######..", "##...##.", "##...##.", "##...##.", "######..",
               "##.##...", "##..##..", "##...##.", "##....##", "##....##"};

    // Reset held: outputs stay zero whatever is driven.
    repeat (8) begin
      mode  = 2'($urandom_range(0, 3));
      OrigX = 10'($urandom_range(0, 639));
      drive(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
            bit'($urandom_range(0, 1)), 1);
    end
    idle(3);
    Reset_n = 1'b1;
    m_rst = 0;
    mode = 2'b00;
    rand_pix(20);

    // STEADY at scale 2
    frame(1, 100, 200);
    steady_points();
    rand_pix(150);

    // Blank slot, then origin latching
    for (int dx = 0; dx < 16; dx++)
      for (int dy = 0; dy < 32; dy++)
        drive(164 + dx, 200 + dy, 0, 1);
    OrigX = 10'd300;
    steady_points();
    frame(1, 300, 200);
    drive(304, 204, 0, 1);
    rand_pix(100);

    // BLINK
    for (int f = 0; f < 6; f++) begin
      frame(2, 100, 200);
      drive(104, 204, 0, 1);
      rand_pix(60);
    end

    // REVEAL
    for (int f = 0; f < 15; f++) begin
      frame(3, 100, 200);
      drive(104, 204, 0, 1);
      drive(122, 204, 0, 1);
      drive(132, 204, 0, 1);
      drive(148, 204, 0, 1);
      rand_pix(40);
    end

    // OFF, then origin near the bottom-right corner
    frame(0, 100, 200);
    rand_pix(200);
    frame(1, 620, 470);
    repeat (150) drive(600 + int'($urandom_range(0, 39)), 460 + int'($urandom_range(0, 19)), 0, 1);
    drive(0, 0, 0, 1);
    drive(0, 470, 0, 1);
    drive(620, 0, 0, 1);

    // Randomised frames
    repeat (30) begin
      frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
      rand_pix(150);
    end

    // Asynchronous reset in the middle of a lit pixel
    frame(1, 100, 200);
    drive(104, 204, 0, 1);
    idle(3);
    @(posedge Clk);
    #1;
    expect_pix(104, 204, t, s);
    check("text_on_before_reset", int'(text_on), int'(t));
    #2;
    Reset_n = 1'b0;
    m_rst = 1;
    m_mode = 0; m_ox = 0; m_oy = 0; m_k = 0;
    #1;
    check("text_on_async_reset", int'(text_on), 0);
    check("char_slot_async_reset", int'(char_slot), 0);
    check("reveal_done_async_reset", int'(reveal_done), 0);
    idle(2);
    Reset_n = 1'b1;
    m_rst = 0;
    mode = 2'b01;
    OrigX = 10'd100;
    OrigY = 10'd200;
    rand_pix(50);
    frame(1, 100, 200);
    drive(104, 204, 0, 1);
    rand_pix(30);
    idle(4);

    check("scoreboard_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
